bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Digit-serial controller for multi-digit BCD addition. Time-shares one single-digit BCD adder across all digit positions, least significant digit first.
- Accepts a start request with two packed BCD operands, sequences one digit per clock, and presents the BCD sum, including the carry-out digit, to the 7-segment display path with a Done pulse.
- Sits between the switch/operand registers and the BCD-to-7-segment decoders, replacing a fully parallel multi-digit adder.

Parameters:
- DIGITS, 2, number of BCD digits per operand (≥1).

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request to add; sampled only in IDLE
- A  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- B  in  4*DIGITS  operand B, packed BCD
- Sum  out  4*(DIGITS+1)  registered BCD result; top digit is carry (0 or 1)
- Busy  out  1  high while digits are being processed
- Done  out  1  one-cycle pulse when Sum/Err are valid
- Err  out  1  operand contained a non-BCD digit (>9); held until next accepted Start

Behaviour:
- Reset (sync, active-high, dominates all else): state=IDLE, Sum=0, Busy=0, Done=0, Err=0, internal digit index=0, carry=0, operand registers=0.
- States: IDLE, ADD, FIN.
- IDLE:
  - Start=0: stay in IDLE.
  - Start=1 at edge k: capture A and B into internal registers; clear Sum, Err, carry, index.
  - Any digit of A or B >9: Err=1 at edge k, go to FIN (no add; Sum stays 0).
  - Otherwise: go to ADD, Busy=1.
- ADD, one digit per edge:
  - t = a[i] + b[i] + carry (5-bit).
  - If t>9: digit = t+6 truncated to 4 bits, carry=1; else digit = t, carry=0.
  - Write Sum digit i, increment index.
  - On the edge processing i=DIGITS-1: also write Sum digit DIGITS = carry-out (0001 or 0000); go to FIN; Busy=0.
- FIN: Done=1 for exactly this cycle. Next edge returns to IDLE, Done=0.
- Latency, valid operands: Start sampled at edge k; Done high in the cycle after edge k+DIGITS. Busy high for exactly DIGITS cycles.
- Latency, invalid operands: Done high in the cycle after edge k. Busy never asserts.
- Start while in ADD or FIN: ignored, no queueing. A/B changes after capture have no effect.
- Sum is registered and holds its final value from FIN until the next accepted Start, which clears it. Intermediate digits may be visible while Busy=1.
- Back-to-back: Start held high continuously is accepted again in the first IDLE cycle after FIN, giving one operation per DIGITS+2 cycles.
- Reset asserted mid-ADD: abort immediately and go to IDLE with all outputs zero; no Done pulse.

Decomposition:
- Shared package:
  - state enum {IDLE, ADD, FIN}
  - DIGIT_W=4, BCD_MAX=9, BCD_ADJ=6
  - function is_bcd(digit)
- Sub-module bcd_digit_add: combinational; inputs a[3:0], b[3:0], cin; outputs s[3:0], cout. The controller instantiates it once and muxes digit i into it.

Test Plan:
- DIGITS=2, A=0x47, B=0x38, Start pulse at edge k → Busy high 2 cycles; Done in cycle after edge k+2; Sum=0x085, Err=0.
- A=0x99, B=0x99 → Sum=0x198, carry digit=1. Then A=0x00, B=0x00 → Sum=0x000, Done after 2 Busy cycles.
- A=0x1A, B=0x05 → Err=1, Sum=0x000, Done in cycle after edge k, Busy never high. A following valid Start clears Err.
- Start pulsed again and A changed during Busy (A=0x47, B=0x38, then A→0x11 mid-op) → second Start ignored; Sum=0x085; only one Done pulse.
- Reset asserted at edge k+1 of an add of 0x55+0x55 → next cycle IDLE, Sum=0, Busy=0, no Done. A new Start then yields Sum=0x110 normally.
- DIGITS=4, Start held high with A=0x9999, B=0x0001 → Sum=0x10000. Done every 6 cycles; each operation re-captures A/B.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_serial_add_ctrl_pkg
// Shared definitions for the digit-serial BCD adder controller:
//   - state_e   : controller states (IDLE, ADD, FIN)
//   - DIGIT_W   : width of one BCD digit
//   - BCD_MAX   : largest legal BCD digit value
//   - BCD_ADJ   : decimal adjust added when a digit sum exceeds BCD_MAX
//   - is_bcd()  : returns 1 when a 4-bit digit is a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder shared by every digit position.
// Ports:
//   a, b  in  4  BCD digits (assumed legal, 0..9)
//   cin   in  1  carry from the previous (less significant) digit
//   s     out 4  BCD sum digit
//   cout  out 1  decimal carry into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t_s;

  // Binary add then decimal adjust: sums above 9 wrap by adding 6 in 4 bits.
  always_comb begin
    t_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (t_s > {1'b0, BCD_MAX}) begin
      s    = t_s[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      s    = t_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Digit-serial multi-digit BCD adder. One bcd_digit_add is time-shared over
// all digit positions, least significant digit first, one digit per clock.
// Parameters:
//   DIGITS        number of BCD digits per operand (>= 1)
// Ports:
//   Clock  in   1             system clock, rising edge
//   Reset  in   1             synchronous active-high reset
//   Start  in   1             add request, only honoured in IDLE
//   A, B   in   4*DIGITS      packed BCD operands, digit 0 in [3:0]
//   Sum    out  4*(DIGITS+1)  registered BCD result, top digit is carry-out
//   Busy   out  1             high while digits are being processed
//   Done   out  1             one-cycle pulse when Sum/Err are valid
//   Err    out  1             an operand held a non-BCD digit; held until the
//                             next accepted Start
// -----------------------------------------------------------------------------
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [DIGIT_W*DIGITS-1:0]     A,
  input  logic [DIGIT_W*DIGITS-1:0]     B,
  output logic [DIGIT_W*(DIGITS+1)-1:0] Sum,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Err
);

  localparam int OP_W  = DIGIT_W * DIGITS;
  localparam int SUM_W = DIGIT_W * (DIGITS + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               carry_r, carry_s;
  logic [OP_W-1:0]    a_r, a_s;
  logic [OP_W-1:0]    b_r, b_s;
  logic [SUM_W-1:0]   sum_r, sum_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;

  logic               operands_ok_s;
  logic [3:0]         dig_a_s;
  logic [3:0]         dig_b_s;
  logic [3:0]         dig_sum_s;
  logic               dig_cout_s;

  // Legality of the live inputs; only consulted on the capture edge.
  always_comb begin
    operands_ok_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      operands_ok_s = operands_ok_s
                    & is_bcd(A[i*DIGIT_W +: DIGIT_W])
                    & is_bcd(B[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Route the current digit of the captured operands into the shared adder.
  always_comb begin
    dig_a_s = a_r[idx_r*DIGIT_W +: DIGIT_W];
    dig_b_s = b_r[idx_r*DIGIT_W +: DIGIT_W];
  end

  bcd_digit_add u_digit_add (
    .a    (dig_a_s),
    .b    (dig_b_s),
    .cin  (carry_r),
    .s    (dig_sum_s),
    .cout (dig_cout_s)
  );

  // Next-state and next-value logic for the controller and its datapath.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    carry_s = carry_r;
    a_s     = a_r;
    b_s     = b_r;
    sum_s   = sum_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = err_r;

    case (state_r)
      IDLE: begin
        if (Start) begin
          a_s     = A;
          b_s     = B;
          sum_s   = '0;
          carry_s = 1'b0;
          idx_s   = '0;
          if (operands_ok_s) begin
            err_s   = 1'b0;
            busy_s  = 1'b1;
            state_s = ADD;
          end else begin
            // Bad digit: skip the add entirely and report straight away.
            err_s   = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ADD: begin
        sum_s[idx_r*DIGIT_W +: DIGIT_W] = dig_sum_s;
        carry_s = dig_cout_s;
        if (idx_r == IDX_LAST) begin
          // Final digit: the carry-out becomes the extra top result digit.
          sum_s[DIGITS*DIGIT_W +: DIGIT_W] = {3'b000, dig_cout_s};
          idx_s   = '0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = FIN;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = ADD;
        end
      end

      FIN: begin
        done_s  = 1'b0;
        state_s = IDLE;
      end

      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any add.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      carry_r <= carry_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sum_r   <= sum_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign Sum  = sum_r;
  assign Busy = busy_r;
  assign Done = done_r;
  assign Err  = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Scoreboard bench for bcd_serial_add_ctrl with a 2-digit and a 4-digit
// instance. Drivers push the expected result (from a decimal-arithmetic
// reference model) when they issue Start; per-instance monitors pop and compare
// on every Done pulse, including Done timing and number of Busy cycles.
// -----------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

  typedef struct {
    logic [19:0] sum;
    logic        err;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  exp_t q2[$];
  exp_t q4[$];

  logic        rst2, start2, busy2, done2, err2;
  logic [7:0]  a2, b2;
  logic [11:0] sum2;
  logic        rst4, start4, busy4, done4, err4;
  logic [15:0] a4, b4;
  logic [19:0] sum4;

  bcd_serial_add_ctrl #(.DIGITS(2)) u_dut2 (
    .Clock(clk), .Reset(rst2), .Start(start2), .A(a2), .B(b2),
    .Sum(sum2), .Busy(busy2), .Done(done2), .Err(err2)
  );

  bcd_serial_add_ctrl #(.DIGITS(4)) u_dut4 (
    .Clock(clk), .Reset(rst4), .Start(start4), .A(a4), .B(b4),
    .Sum(sum4), .Busy(busy4), .Done(done4), .Err(err4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: decode BCD to integers, add in decimal, re-encode nd+1 digits.
  function automatic exp_t model(input int nd, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int va, vb, p, s, da, db;
    bit bad;
    va = 0; vb = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < nd; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1'b1;
      va += da * p;
      vb += db * p;
      p  *= 10;
    end
    e.sum = '0;
    e.done_cyc = 0;
    if (bad) begin
      e.err    = 1'b1;
      e.busy_n = 0;
    end else begin
      e.err    = 1'b0;
      e.busy_n = nd;
      s = va + vb;
      for (int i = 0; i <= nd; i++) begin
        e.sum[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_bcd(input int nd);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 19) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Called just after a rising edge; Start is seen on the next edge.
  task automatic op2(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = model(2, {8'h00, a}, {8'h00, b});
    e.done_cyc = cyc + 1 + (e.err ? 0 : 2);
    a2 = a; b2 = b; start2 = 1'b1;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(4, a, b);
    e.done_cyc = cyc + 1 + (e.err ? 0 : 4);
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (q2.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (q2.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout2: %0d results outstanding, required 0", q2.size());
      q2.delete();
    end
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (q4.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q4.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout4: %0d results outstanding, required 0", q4.size());
      q4.delete();
    end
  endtask

  // Monitor for the 2-digit instance.
  initial begin
    int bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst2 === 1'b1) begin
        bcnt = 0;
      end else begin
        if (busy2 === 1'b1) bcnt++;
        if (done2 === 1'b1) begin
          if (q2.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL done2_unexpected: got Done=1 required Done=0 (cycle %0d)", cyc);
          end else begin
            e = q2.pop_front();
            check("sum2", 32'(sum2), 32'(e.sum));
            check("err2", 32'(err2), 32'(e.err));
            check("done_cyc2", cyc, e.done_cyc);
            check("busy_n2", bcnt, e.busy_n);
          end
          bcnt = 0;
        end
      end
    end
  end

  // Monitor for the 4-digit instance.
  initial begin
    int bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst4 === 1'b1) begin
        bcnt = 0;
      end else begin
        if (busy4 === 1'b1) bcnt++;
        if (done4 === 1'b1) begin
          if (q4.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL done4_unexpected: got Done=1 required Done=0 (cycle %0d)", cyc);
          end else begin
            e = q4.pop_front();
            check("sum4", 32'(sum4), 32'(e.sum));
            check("err4", 32'(err4), 32'(e.err));
            check("done_cyc4", cyc, e.done_cyc);
            check("busy_n4", bcnt, e.busy_n);
          end
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus.
  initial begin
    int n;
    exp_t e;
    rst2 = 1'b1; start2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
    rst4 = 1'b1; start4 = 1'b0; a4 = 16'h0000; b4 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum2", 32'(sum2), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    check("rst_err2", 32'(err2), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    rst2 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    // Basic adds, full carry, zero.
    op2(8'h47, 8'h38); wait_idle2();
    op2(8'h99, 8'h99); wait_idle2();
    op2(8'h00, 8'h00); wait_idle2();

    // Non-BCD operand, Err holds in IDLE, next valid Start clears it.
    op2(8'h1A, 8'h05); wait_idle2();
    repeat (3) @(posedge clk);
    #1;
    check("err2_hold", 32'(err2), 32'd1);
    check("sum2_after_err", 32'(sum2), 32'd0);
    op2(8'h12, 8'h34); wait_idle2();

    // Second Start and operand change while busy are ignored.
    op2(8'h47, 8'h38);
    a2 = 8'h11; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_idle2();
    repeat (4) @(posedge clk);
    #1;
    check("sum2_hold", 32'(sum2), 32'h085);

    // Reset one edge into an add aborts it without a Done pulse.
    op2(8'h55, 8'h55);
    rst2 = 1'b1;
    q2.delete();
    @(posedge clk); #1;
    check("abort_sum2", 32'(sum2), 32'd0);
    check("abort_busy2", 32'(busy2), 32'd0);
    check("abort_done2", 32'(done2), 32'd0);
    check("abort_err2", 32'(err2), 32'd0);
    rst2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op2(8'h55, 8'h55); wait_idle2();

    // Random traffic on the 2-digit instance.
    for (int i = 0; i < 40; i++) begin
      op2(rand_bcd(2)[7:0], rand_bcd(2)[7:0]);
      wait_idle2();
    end

    // 4 digits, Start held high: one op every 6 cycles, operands re-captured.
    n = cyc;
    a4 = 16'h9999; b4 = 16'h0001; start4 = 1'b1;
    e = model(4, 16'h9999, 16'h0001); e.done_cyc = n + 5;  q4.push_back(e);
    e = model(4, 16'h1234, 16'h0001); e.done_cyc = n + 11; q4.push_back(e);
    e = model(4, 16'h9999, 16'h0001); e.done_cyc = n + 17; q4.push_back(e);
    while (cyc < n + 2) begin @(posedge clk); #1; end
    a4 = 16'h1234;
    while (cyc < n + 8) begin @(posedge clk); #1; end
    a4 = 16'h9999;
    while (cyc < n + 13) begin @(posedge clk); #1; end
    start4 = 1'b0;
    wait_idle4();
    repeat (8) @(posedge clk);
    #1;
    check("sum4_final", 32'(sum4), 32'h10000);

    // Random traffic on the 4-digit instance.
    for (int i = 0; i < 20; i++) begin
      op4(rand_bcd(4), rand_bcd(4));
      wait_idle4();
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
